// File: rtl/score_digit_source.sv
// Score and high-score keeper for the Dino_run 4-digit seven-segment display.
// Holds both values as 4-digit BCD, picks one for display, and drives the
// registered digit value/enable pairs with optional leading-zero blanking.
// Digit 0 is the rightmost, least significant digit.
module score_digit_source #(
   parameter bit BLANK_LEADING = 1'b1, // 1: blank leading zeros, 0: all digits lit
   parameter bit SATURATE      = 1'b1  // 1: hold at 9999, 0: wrap to 0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        inc_i,
   input  logic        freeze_i,
   input  logic        show_hi_i,
   output logic        digit0_en_o,
   output logic [3:0]  digit0_o,
   output logic        digit1_en_o,
   output logic [3:0]  digit1_o,
   output logic        digit2_en_o,
   output logic [3:0]  digit2_o,
   output logic        digit3_en_o,
   output logic [3:0]  digit3_o,
   output logic [15:0] score_o,
   output logic [15:0] hi_score_o,
   output logic        new_hi_o
);

   localparam logic [15:0] BCD_MAX  = 16'h9999;
   localparam logic [15:0] BCD_ZERO = 16'h0000;

   // State registers.
   logic [15:0] r_score;
   logic [15:0] r_hi;
   logic        r_new_hi;

   // Registered display outputs.
   logic [3:0]  r_digit0;
   logic [3:0]  r_digit1;
   logic [3:0]  r_digit2;
   logic [3:0]  r_digit3;
   logic        r_en0;
   logic        r_en1;
   logic        r_en2;
   logic        r_en3;

   // Combinational next-state and display-selection nets.
   logic [15:0] w_score_inc;
   logic [15:0] w_score_d;
   logic        w_hi_raise;
   logic [15:0] w_disp;
   logic        w_en1;
   logic        w_en2;
   logic        w_en3;

   // Decimal increment of a 4-digit BCD word. Each nibble rolls 9 -> 0 and
   // carries into the next; 9999 rolls to 0000, and the caller decides
   // whether that wrap is allowed.
   function automatic logic [15:0] f_bcd_inc(input logic [15:0] v);
      logic [15:0] res;
      logic        carry;
      res   = v;
      carry = 1'b1;
      for (int n = 0; n < 4; n++) begin
         if (carry) begin
            if (v[n*4 +: 4] == 4'd9) begin
               res[n*4 +: 4] = 4'd0;
            end else begin
               res[n*4 +: 4] = v[n*4 +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end
      end
      return res;
   endfunction

   // Candidate incremented score, before the saturate/wrap decision.
   always_comb begin
      w_score_inc = f_bcd_inc(r_score);
   end

   // Next score: clear beats freeze, freeze beats inc; otherwise hold.
   always_comb begin
      w_score_d = r_score;
      if (clear_i) begin
         w_score_d = BCD_ZERO;
      end else if (freeze_i) begin
         w_score_d = r_score;
      end else if (inc_i) begin
         if (r_score == BCD_MAX) begin
            w_score_d = SATURATE ? BCD_MAX : BCD_ZERO;
         end else begin
            w_score_d = w_score_inc;
         end
      end
   end

   // BCD words order the same as their decimal values, so a plain unsigned
   // compare decides a new high score. A wrap to 0000 can never exceed it.
   always_comb begin
      w_hi_raise = (w_score_d > r_hi);
   end

   // Score, high score and the new-high flag for the current game.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_score  <= BCD_ZERO;
         r_hi     <= BCD_ZERO;
         r_new_hi <= 1'b0;
      end else begin
         r_score <= w_score_d;
         if (w_hi_raise) begin
            r_hi <= w_score_d;
         end
         if (clear_i) begin
            r_new_hi <= 1'b0;
         end else if (w_hi_raise) begin
            r_new_hi <= 1'b1;
         end
      end
   end

   // Display source selection and leading-zero enables, taken from the
   // registered state so the display trails the score by one cycle.
   always_comb begin
      w_disp = show_hi_i ? r_hi : r_score;
      if (BLANK_LEADING) begin
         w_en3 = (w_disp[15:12] != 4'd0);
         w_en2 = w_en3 | (w_disp[11:8] != 4'd0);
         w_en1 = w_en2 | (w_disp[7:4] != 4'd0);
      end else begin
         w_en3 = 1'b1;
         w_en2 = 1'b1;
         w_en1 = 1'b1;
      end
   end

   // Registered digit values and enables; blanked digits still carry 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_digit0 <= 4'd0;
         r_digit1 <= 4'd0;
         r_digit2 <= 4'd0;
         r_digit3 <= 4'd0;
         r_en0    <= 1'b1;
         r_en1    <= !BLANK_LEADING;
         r_en2    <= !BLANK_LEADING;
         r_en3    <= !BLANK_LEADING;
      end else begin
         r_digit0 <= w_disp[3:0];
         r_digit1 <= w_disp[7:4];
         r_digit2 <= w_disp[11:8];
         r_digit3 <= w_disp[15:12];
         r_en0    <= 1'b1;
         r_en1    <= w_en1;
         r_en2    <= w_en2;
         r_en3    <= w_en3;
      end
   end

   assign score_o     = r_score;
   assign hi_score_o  = r_hi;
   assign new_hi_o    = r_new_hi;
   assign digit0_o    = r_digit0;
   assign digit1_o    = r_digit1;
   assign digit2_o    = r_digit2;
   assign digit3_o    = r_digit3;
   assign digit0_en_o = r_en0;
   assign digit1_en_o = r_en1;
   assign digit2_en_o = r_en2;
   assign digit3_en_o = r_en3;

endmodule

// File: tb/tb_score_digit_source.sv
// Directed bench for score_digit_source. Two instances share stimulus: the
// default build (blanking, saturating) and a wrapping, unblanked build.
module tb_score_digit_source;

   logic clk;
   logic rst_n;
   logic clear;
   logic inc;
   logic freeze;
   logic show_hi;

   // Default instance outputs.
   logic        d0_en, d1_en, d2_en, d3_en;
   logic [3:0]  d0, d1, d2, d3;
   logic [15:0] score, hi;
   logic        new_hi;

   // Wrapping / unblanked instance outputs.
   logic        w0_en, w1_en, w2_en, w3_en;
   logic [3:0]  w0, w1, w2, w3;
   logic [15:0] w_score, w_hi;
   logic        w_new_hi;

   int n_checks = 0;
   int n_errors = 0;

   score_digit_source dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .inc_i(inc),
      .freeze_i(freeze), .show_hi_i(show_hi),
      .digit0_en_o(d0_en), .digit0_o(d0), .digit1_en_o(d1_en), .digit1_o(d1),
      .digit2_en_o(d2_en), .digit2_o(d2), .digit3_en_o(d3_en), .digit3_o(d3),
      .score_o(score), .hi_score_o(hi), .new_hi_o(new_hi)
   );

   score_digit_source #(.BLANK_LEADING(1'b0), .SATURATE(1'b0)) dut_w (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .inc_i(inc),
      .freeze_i(freeze), .show_hi_i(show_hi),
      .digit0_en_o(w0_en), .digit0_o(w0), .digit1_en_o(w1_en), .digit1_o(w1),
      .digit2_en_o(w2_en), .digit2_o(w2), .digit3_en_o(w3_en), .digit3_o(w3),
      .score_o(w_score), .hi_score_o(w_hi), .new_hi_o(w_new_hi)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_inc(input int n);
      inc = 1'b1;
      repeat (n) tick();
      inc = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; inc = 1'b0; freeze = 1'b0; show_hi = 1'b0;
      #12;
      // Reset state.
      check("rst_score", score, 16'h0000);
      check("rst_hi", hi, 16'h0000);
      check("rst_new_hi", new_hi, 1'b0);
      check("rst_en", {d3_en, d2_en, d1_en, d0_en}, 4'b0001);
      check("rst_d0", d0, 4'd0);
      check("rst_w_en", {w3_en, w2_en, w1_en, w0_en}, 4'b1111);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_score", score, 16'h0000);

      // Nine points, then one more crosses into the tens digit.
      run_inc(9);
      check("score_9", score, 16'h0009);
      run_inc(1);
      check("score_10", score, 16'h0010);
      check("hi_10", hi, 16'h0010);
      check("new_hi_10", new_hi, 1'b1);
      check("disp_lag1_d0", d0, 4'd9);
      tick();
      check("disp_10_digits", {d3, d2, d1, d0}, 16'h0010);
      check("disp_10_en", {d3_en, d2_en, d1_en, d0_en}, 4'b0011);

      // Freeze masks increments.
      freeze = 1'b1;
      run_inc(5);
      freeze = 1'b0;
      check("freeze_score", score, 16'h0010);
      check("freeze_hi", hi, 16'h0010);

      // Build 0123, then clear with a simultaneous inc.
      pulse_clear();
      check("clear_score", score, 16'h0000);
      check("clear_new_hi", new_hi, 1'b0);
      run_inc(123);
      check("score_123", score, 16'h0123);
      check("hi_123", hi, 16'h0123);
      clear = 1'b1; inc = 1'b1;
      tick();
      clear = 1'b0; inc = 1'b0;
      check("clr_inc_score", score, 16'h0000);
      check("clr_inc_hi", hi, 16'h0123);
      check("clr_inc_new_hi", new_hi, 1'b0);
      run_inc(123);
      check("tie_hi", hi, 16'h0123);
      check("tie_new_hi", new_hi, 1'b0);
      run_inc(1);
      check("score_124", score, 16'h0124);
      check("hi_124", hi, 16'h0124);
      check("new_hi_124", new_hi, 1'b1);

      // Display selection and blanking on 0007 vs hi 0124.
      pulse_clear();
      run_inc(7);
      tick();
      check("disp_7_digits", {d3, d2, d1, d0}, 16'h0007);
      check("disp_7_en", {d3_en, d2_en, d1_en, d0_en}, 4'b0001);
      check("w_disp_7_en", {w3_en, w2_en, w1_en, w0_en}, 4'b1111);
      check("w_disp_7_d0", w0, 4'd7);
      show_hi = 1'b1;
      tick();
      check("disp_hi_digits", {d3, d2, d1, d0}, 16'h0124);
      check("disp_hi_en", {d3_en, d2_en, d1_en, d0_en}, 4'b0111);
      show_hi = 1'b0;
      tick();
      check("disp_back_digits", {d3, d2, d1, d0}, 16'h0007);

      // Top of range: saturate on the default build, wrap on the other.
      pulse_clear();
      run_inc(9999);
      check("score_9999", score, 16'h9999);
      check("w_score_9999", w_score, 16'h9999);
      run_inc(1);
      check("sat_score", score, 16'h9999);
      check("wrap_score", w_score, 16'h0000);
      check("wrap_hi", w_hi, 16'h9999);
      check("wrap_new_hi", w_new_hi, 1'b1);
      run_inc(1);
      check("sat_score2", score, 16'h9999);
      check("wrap_score1", w_score, 16'h0001);
      check("sat_disp_digits", {d3, d2, d1, d0}, 16'h9999);
      check("sat_disp_en", {d3_en, d2_en, d1_en, d0_en}, 4'b1111);

      // Asynchronous reset between edges, mid-count.
      inc = 1'b1;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_score", score, 16'h0000);
      check("arst_hi", hi, 16'h0000);
      check("arst_new_hi", new_hi, 1'b0);
      check("arst_digits", {d3, d2, d1, d0}, 16'h0000);
      check("arst_en", {d3_en, d2_en, d1_en, d0_en}, 4'b0001);
      check("arst_w_hi", w_hi, 16'h0000);
      check("arst_w_en", {w3_en, w2_en, w1_en, w0_en}, 4'b1111);
      inc = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
